// File: rtl/spi_xfer_ctrl.sv
// SPI master sequencer: SCLK, slave select, load/capture pulses and per-edge shift/sample strobes for spi_shifter. Optional abort path under SPI_XFER_ABORT_EN.
// Latency: ss_o/busy_o/send_data_o one cycle after an accepted start_i; frame holds ss_o low for (2*DATA_W+2)*HALF cycles.
// Backpressure: none; start_i is dropped while busy_o, spe_i low or mstr_i low; spe_i low mid-frame returns to idle.
module spi_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 11
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       spe_i,
    input  logic       mstr_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic [2:0] sppr_i,
    input  logic [2:0] spr_i,
    input  logic       start_i,
`ifdef SPI_XFER_ABORT_EN
    input  logic       abort_i,
    output logic       aborted_o,
`endif
    output logic       sclk_o,
    output logic       ss_o,
    output logic       send_data_o,
    output logic       receive_data_o,
    output logic       mosi_send_sclk_o,
    output logic       mosi_send_sclk0_o,
    output logic       miso_receive_sclk_o,
    output logic       miso_receive_sclk0_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int EDGES = 2 * DATA_W;
    localparam int HW    = $clog2(EDGES) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [HW-1:0] HP_LAST      = HW'(EDGES - 1);
    localparam logic [HW-1:0] EDGE_END     = HW'(EDGES);
    localparam logic [HW-1:0] EDGE_PENULT  = HW'(EDGES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_m1;
    logic [HW-1:0]    hp_cnt;
    logic             cpol_q;
    logic             cpha_q;
    logic             sclk_q;
    logic             send_q;
    logic             recv_q;
    logic             done_q;
`ifdef SPI_XFER_ABORT_EN
    logic             abt_q;
`endif

    logic [CNT_W-1:0] half_sel;
    logic [CNT_W-1:0] half_m1_sel;
    logic             tick;
    logic [HW-1:0]    next_edge;
    logic             edge_now;
    logic             is_sample;
    logic             is_shift;
    logic             last_sample;

    // Half-period in PCLK cycles: (sppr+1) * 2^spr, i.e. half the baud divisor.
    assign half_sel    = (CNT_W'(sppr_i) + CNT_W'(1)) << spr_i;
    assign half_m1_sel = half_sel - CNT_W'(1);

    assign tick = (cnt == half_m1);

    // With cpha=1 the first edge closes SETUP, so every TRANSFER half-period is one edge further on.
    always_comb begin
        next_edge = '0;
        if (state == ST_SETUP) begin
            next_edge = HW'(1);
        end else if (cpha_q) begin
            next_edge = hp_cnt + HW'(2);
        end else begin
            next_edge = hp_cnt + HW'(1);
        end
    end

    always_comb begin
        edge_now = 1'b0;
        if (tick) begin
            if (state == ST_SETUP) begin
                edge_now = cpha_q;
            end else if (state == ST_XFER) begin
                edge_now = !cpha_q || (hp_cnt != HP_LAST);
            end
        end
    end

    assign is_sample   = next_edge[0] ^ cpha_q;
    assign is_shift    = !is_sample && !(!cpha_q && (next_edge == EDGE_END));
    assign last_sample = is_sample && (next_edge == (cpha_q ? EDGE_END : EDGE_PENULT));

    assign mosi_send_sclk_o     = edge_now && is_shift  && !sclk_q;
    assign mosi_send_sclk0_o    = edge_now && is_shift  &&  sclk_q;
    assign miso_receive_sclk_o  = edge_now && is_sample && !sclk_q;
    assign miso_receive_sclk0_o = edge_now && is_sample &&  sclk_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            half_m1 <= '0;
            hp_cnt  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sclk_q  <= 1'b0;
            send_q  <= 1'b0;
            recv_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_XFER_ABORT_EN
            abt_q   <= 1'b0;
`endif
        end else begin
            send_q <= 1'b0;
            recv_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SPI_XFER_ABORT_EN
            abt_q  <= 1'b0;
`endif
            if (state == ST_IDLE) begin
                sclk_q <= cpol_i;
                cnt    <= '0;
                hp_cnt <= '0;
                if (start_i && spe_i && mstr_i) begin
                    state   <= ST_SETUP;
                    cpol_q  <= cpol_i;
                    cpha_q  <= cpha_i;
                    half_m1 <= half_m1_sel;
                    send_q  <= 1'b1;
                end
            end else if (!spe_i) begin
                state  <= ST_IDLE;
                sclk_q <= cpol_i;
            end
`ifdef SPI_XFER_ABORT_EN
            else if (abort_i) begin
                state  <= ST_IDLE;
                sclk_q <= cpol_q;
                abt_q  <= 1'b1;
            end
`endif
            else begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
                if (edge_now) begin
                    sclk_q <= ~sclk_q;
                    recv_q <= last_sample;
                end
                case (state)
                    ST_SETUP: begin
                        if (tick) begin
                            state <= ST_XFER;
                        end
                    end
                    ST_XFER: begin
                        if (tick) begin
                            if (hp_cnt == HP_LAST) begin
                                state <= ST_HOLD;
                            end else begin
                                hp_cnt <= hp_cnt + HW'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (tick) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                            sclk_q <= cpol_q;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sclk_o         = sclk_q;
    assign ss_o           = (state == ST_IDLE);
    assign busy_o         = (state != ST_IDLE);
    assign send_data_o    = send_q;
    assign receive_data_o = recv_q;
    assign done_o         = done_q;
`ifdef SPI_XFER_ABORT_EN
    assign aborted_o      = abt_q;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: table of frame configurations with expected totals, per-cycle reference model,
// hand-written corner sequences (ignored starts, mid-frame disturbance, spe drop, reset, abort) and random frames.
module tb_spi_xfer_ctrl;

    localparam int EDG = 16;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       spe_i, mstr_i, cpol_i, cpha_i, start_i;
    logic [2:0] sppr_i, spr_i;
    logic       sclk_o, ss_o, send_data_o, receive_data_o;
    logic       mosi_send_sclk_o, mosi_send_sclk0_o, miso_receive_sclk_o, miso_receive_sclk0_o;
    logic       busy_o, done_o;
    logic       abt_w;
`ifdef SPI_XFER_ABORT_EN
    logic       abort_i;
    logic       aborted_o;
    assign abt_w = aborted_o;
`else
    assign abt_w = 1'b0;
`endif

    spi_xfer_ctrl dut (
        .PCLK                 (PCLK),
        .PRESET               (PRESET),
        .spe_i                (spe_i),
        .mstr_i               (mstr_i),
        .cpol_i               (cpol_i),
        .cpha_i               (cpha_i),
        .sppr_i               (sppr_i),
        .spr_i                (spr_i),
        .start_i              (start_i),
`ifdef SPI_XFER_ABORT_EN
        .abort_i              (abort_i),
        .aborted_o            (aborted_o),
`endif
        .sclk_o               (sclk_o),
        .ss_o                 (ss_o),
        .send_data_o          (send_data_o),
        .receive_data_o       (receive_data_o),
        .mosi_send_sclk_o     (mosi_send_sclk_o),
        .mosi_send_sclk0_o    (mosi_send_sclk0_o),
        .miso_receive_sclk_o  (miso_receive_sclk_o),
        .miso_receive_sclk0_o (miso_receive_sclk0_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 PCLK = ~PCLK;

    // {sclk, ss, send, recv, mosi_r, mosi_f, miso_r, miso_f, busy, done, aborted}
    logic [10:0] dv;
    assign dv = {sclk_o, ss_o, send_data_o, receive_data_o, mosi_send_sclk_o, mosi_send_sclk0_o,
                 miso_receive_sclk_o, miso_receive_sclk0_o, busy_o, done_o, abt_w};

    int n_cmp = 0;
    int n_err = 0;
    int c_ss, c_edges, c_mr, c_mf, c_sr, c_sf, c_rx, c_done, c_abt;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [2:0] sppr;
        logic [2:0] spr;
        int         ss_low;
        int         edges;
        int         mr;
        int         mf;
        int         sr;
        int         sf;
        int         rx;
        int         done;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Expected outputs k cycles after the start was sampled. Half-period hp (0 = setup, 1..16 = transfer,
    // 17 = hold); edge e ends half-period e (cpha=0) or e-1 (cpha=1).
    function automatic logic [10:0] model(input int k, input logic cpol, input logic cpha, input int half,
                                          input int kill_k, input int kill_kind);
        logic [10:0] r;
        int total, hp, p, nb, e;
        logic smp;
        r = '0;
        total = 18 * half;
        if (kill_k > 0 && k > kill_k) begin
            r[9]  = 1'b1;
            r[10] = (kill_kind == 2 && k == kill_k + 1) ? 1'b0 : cpol;
            r[0]  = (kill_kind == 3 && k == kill_k + 1);
            return r;
        end
        if (k < 1 || k > total) begin
            r[9]  = 1'b1;
            r[10] = cpol;
            r[1]  = (k == total + 1);
            return r;
        end
        hp = (k - 1) / half;
        p  = (k - 1) % half;
        r[2] = 1'b1;
        r[8] = (k == 1);
        nb = 0;
        for (int i = 1; i <= EDG; i++) begin
            if ((cpha ? i - 1 : i) < hp) nb++;
        end
        r[10] = cpol ^ nb[0];
        e = cpha ? hp + 1 : hp;
        if (p == half - 1 && e >= 1 && e <= EDG) begin
            smp = (((e % 2) == 1) == (cpha == 1'b0));
            if (smp) begin
                if (r[10]) r[3] = 1'b1; else r[4] = 1'b1;
            end else if (!(cpha == 1'b0 && e == EDG)) begin
                if (r[10]) r[5] = 1'b1; else r[6] = 1'b1;
            end
        end
        // Last sample edge always ends half-period 15; the capture pulse shows one cycle later.
        r[7] = (p == 0 && hp == 16);
        return r;
    endfunction

    // kill_kind: 1 = spe_i drop, 2 = PRESET pulse, 3 = abort_i pulse; dist_k re-pulses start and changes registers.
    task automatic run_frame(input logic cpol, input logic cpha, input logic [2:0] sppr, input logic [2:0] spr,
                             input int kill_k, input int kill_kind, input int dist_k, input string tag);
        int half, total, last_k;
        logic prev_sclk;
        logic [10:0] exp;
        half   = (int'(sppr) + 1) << int'(spr);
        total  = 18 * half;
        last_k = (kill_k > 0) ? kill_k + 3 : total + 2;
        c_ss = 0; c_edges = 0; c_mr = 0; c_mf = 0; c_sr = 0; c_sf = 0; c_rx = 0; c_done = 0; c_abt = 0;
        @(negedge PCLK);
        cpol_i = cpol; cpha_i = cpha; sppr_i = sppr; spr_i = spr;
        spe_i = 1'b1; mstr_i = 1'b1; start_i = 1'b1;
        prev_sclk = cpol;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge PCLK);
            if (k == 1) start_i = 1'b0;
            exp = model(k, cpol, cpha, half, kill_k, kill_kind);
            check_vec($sformatf("%s k=%0d", tag, k), dv, exp);
            if (!ss_o) c_ss++;
            if (sclk_o != prev_sclk) c_edges++;
            prev_sclk = sclk_o;
            c_mr += int'(mosi_send_sclk_o);
            c_mf += int'(mosi_send_sclk0_o);
            c_sr += int'(miso_receive_sclk_o);
            c_sf += int'(miso_receive_sclk0_o);
            c_rx += int'(receive_data_o);
            c_done += int'(done_o);
            c_abt += int'(abt_w);
            if (k == kill_k) begin
                if (kill_kind == 1) spe_i = 1'b0;
                if (kill_kind == 2) PRESET = 1'b1;
`ifdef SPI_XFER_ABORT_EN
                if (kill_kind == 3) abort_i = 1'b1;
`endif
            end
            if (kill_k > 0 && k == kill_k + 1) begin
                PRESET = 1'b0;
`ifdef SPI_XFER_ABORT_EN
                abort_i = 1'b0;
`endif
            end
            if (dist_k > 0 && k == dist_k) begin
                start_i = 1'b1;
                sppr_i  = ~sppr;
                spr_i   = spr ^ 3'd1;
                cpha_i  = ~cpha;
            end
            if (dist_k > 0 && k == dist_k + 1) start_i = 1'b0;
        end
        start_i = 1'b0;
        spe_i   = 1'b1;
    endtask

    task automatic idle_checks(input string tag, input logic cpol);
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            start_i = 1'b0;
            check_vec($sformatf("%s k=%0d", tag, k), dv, {cpol, 1'b1, 9'b0});
        end
    endtask

    initial begin
        logic       r_cpol, r_cpha;
        logic [2:0] r_sppr, r_spr;
        int         r_half, r_kill, r_dist;

        tbl[0] = '{1'b0, 1'b0, 3'd0, 3'd0,    18, 16, 0, 7, 8, 0, 1, 1};
        tbl[1] = '{1'b1, 1'b1, 3'd1, 3'd1,    72, 16, 0, 8, 8, 0, 1, 1};
        tbl[2] = '{1'b0, 1'b1, 3'd2, 3'd0,    54, 16, 8, 0, 0, 8, 1, 1};
        tbl[3] = '{1'b1, 1'b0, 3'd0, 3'd2,    72, 16, 7, 0, 0, 8, 1, 1};
        tbl[4] = '{1'b0, 1'b0, 3'd7, 3'd0,   144, 16, 0, 7, 8, 0, 1, 1};
        tbl[5] = '{1'b1, 1'b1, 3'd7, 3'd7, 18432, 16, 0, 8, 8, 0, 1, 1};

        PRESET = 1'b1; spe_i = 1'b1; mstr_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0;
        sppr_i = 3'd0; spr_i = 3'd0; start_i = 1'b0;
`ifdef SPI_XFER_ABORT_EN
        abort_i = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            @(negedge PCLK);
            check_vec($sformatf("reset cyc%0d", i), dv, 11'b01000000000);
        end
        PRESET = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].cpol, tbl[i].cpha, tbl[i].sppr, tbl[i].spr, 0, 0, 0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d ss_low", i), c_ss, tbl[i].ss_low);
            check($sformatf("tbl%0d edges", i), c_edges, tbl[i].edges);
            check($sformatf("tbl%0d mosi_r", i), c_mr, tbl[i].mr);
            check($sformatf("tbl%0d mosi_f", i), c_mf, tbl[i].mf);
            check($sformatf("tbl%0d miso_r", i), c_sr, tbl[i].sr);
            check($sformatf("tbl%0d miso_f", i), c_sf, tbl[i].sf);
            check($sformatf("tbl%0d rx", i), c_rx, tbl[i].rx);
            check($sformatf("tbl%0d done", i), c_done, tbl[i].done);
        end

        @(negedge PCLK);
        cpol_i = 1'b0; mstr_i = 1'b0; start_i = 1'b1;
        idle_checks("nomstr", 1'b0);
        mstr_i = 1'b1; spe_i = 1'b0; start_i = 1'b1;
        idle_checks("nospe", 1'b0);
        spe_i = 1'b1;

        run_frame(1'b0, 1'b0, 3'd1, 3'd0, 0, 0, 10, "dist");
        check("dist done", c_done, 1);
        check("dist ss_low", c_ss, 36);
        check("dist edges", c_edges, 16);

        run_frame(1'b0, 1'b0, 3'd1, 3'd0, 13, 1, 0, "spedrop");
        check("spedrop done", c_done, 0);
        check("spedrop rx", c_rx, 0);
        run_frame(1'b0, 1'b0, 3'd0, 3'd0, 0, 0, 0, "fresh");
        check("fresh done", c_done, 1);
        check("fresh ss_low", c_ss, 18);

        run_frame(1'b1, 1'b1, 3'd0, 3'd1, 7, 2, 0, "midreset");
        check("midreset done", c_done, 0);

`ifdef SPI_XFER_ABORT_EN
        run_frame(1'b0, 1'b0, 3'd0, 3'd0, 11, 3, 0, "abort");
        check("abort pulses", c_abt, 1);
        check("abort rx", c_rx, 0);
        check("abort done", c_done, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            r_cpol = 1'($urandom_range(0, 1));
            r_cpha = 1'($urandom_range(0, 1));
            r_sppr = 3'($urandom_range(0, 7));
            r_spr  = 3'($urandom_range(0, 2));
            r_half = (int'(r_sppr) + 1) << int'(r_spr);
            r_kill = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18 * r_half)) : 0;
            r_dist = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 18 * r_half - 2)) : 0;
            run_frame(r_cpol, r_cpha, r_sppr, r_spr, r_kill, 1, r_dist, $sformatf("rnd%0d", i));
            check($sformatf("rnd%0d done", i), c_done, (r_kill == 0) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
